// File: rtl/lcd_bcd_timer.sv
// N-digit BCD up/down timer with run/stop, synchronous load/clear and an
// LCD write sequencer that redraws the count whenever it changes.
module lcd_bcd_timer #(
    parameter int DIGITS      = 4,
    parameter int TICK_DIV    = 500000,
    parameter int SETTLE      = 262142,
    parameter int LEAD_BLANKS = 2,
    parameter int ZERO_BLANK  = 0
) (
    input  logic                CLOCK_50,
    input  logic                RST,
    input  logic                run_toggle,
    input  logic                dir,
    input  logic                clear,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_value,
    output logic [4*DIGITS-1:0] count,
    output logic                running,
    output logic                wrap,
    output logic [7:0]          lcd_data,
    output logic                lcd_rs,
    output logic                lcd_start,
    input  logic                lcd_done
);
    localparam int CW        = 4 * DIGITS;
    localparam int DW        = $clog2(TICK_DIV);
    localparam int SW        = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int FRAME_IDX = 4;
    localparam int LAST_IDX  = FRAME_IDX + LEAD_BLANKS + DIGITS;
    localparam int IW        = $clog2(LAST_IDX + 1);

    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SET_LAST = (SETTLE > 0) ? SW'(SETTLE - 1) : '0;

    // ---------------------------------------------------------------
    // BCD helpers
    // ---------------------------------------------------------------
    function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        logic          c;
        r = v;
        c = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (c) begin
                if (v[4*k +: 4] >= 4'd9) begin
                    r[4*k +: 4] = 4'd0;
                end else begin
                    r[4*k +: 4] = v[4*k +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        logic          b;
        r = v;
        b = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (b) begin
                if (v[4*k +: 4] == 4'd0) begin
                    r[4*k +: 4] = 4'd9;
                end else begin
                    r[4*k +: 4] = v[4*k +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [CW-1:0] bcd_sat(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        r = v;
        for (int k = 0; k < DIGITS; k++) begin
            if (v[4*k +: 4] > 4'd9)
                r[4*k +: 4] = 4'd9;
        end
        return r;
    endfunction

    // ---------------------------------------------------------------
    // Tick divider and counter
    // ---------------------------------------------------------------
    logic [DW-1:0] div;
    logic          tick;
    logic          all9;
    logic          all0;

    // tick uses the pre-toggle running state, so a toggle on a tick cycle still counts
    assign tick = running && (div == DIV_LAST);
    assign all9 = (count == {DIGITS{4'h9}});
    assign all0 = (count == '0);

    always_ff @(posedge CLOCK_50 or negedge RST) begin
        if (!RST) begin
            count <= '0;
            div   <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (clear) begin
                count <= '0;
                div   <= '0;
            end else if (load) begin
                count <= bcd_sat(load_value);
                div   <= '0;
            end else if (tick) begin
                div   <= '0;
                count <= dir ? bcd_inc(count) : bcd_dec(count);
                wrap  <= dir ? all9 : all0;
            end else if (running) begin
                div <= div + DW'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RST) begin
        if (!RST)
            running <= 1'b0;
        else if (run_toggle)
            running <= ~running;
    end

    // ---------------------------------------------------------------
    // Display snapshot and dirty tracking
    // ---------------------------------------------------------------
    logic [CW-1:0] snap;
    logic          dirty;
    logic          snap_take;

    always_ff @(posedge CLOCK_50 or negedge RST) begin
        if (!RST) begin
            snap  <= '0;
            dirty <= 1'b0;
        end else if (snap_take) begin
            snap  <= count;
            dirty <= 1'b0;
        end else if (count != snap) begin
            dirty <= 1'b1;
        end
    end

    logic [DIGITS-1:0] blank;
    logic              lead;

    // digit 0 is never blanked, so the loop stops at k=1
    always_comb begin
        blank = '0;
        lead  = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            lead     = lead && (snap[4*k +: 4] == 4'd0);
            blank[k] = (ZERO_BLANK != 0) && lead;
        end
    end

    // ---------------------------------------------------------------
    // Write list: idx 0..3 init, 4 = home, then blanks, then digits MSB-first
    // ---------------------------------------------------------------
    typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_SETTLE, S_NEXT} seq_t;

    seq_t          state;
    seq_t          state_nxt;
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_nxt;
    logic [SW-1:0] scnt;
    logic [SW-1:0] scnt_nxt;
    logic [7:0]    data_nxt;
    logic          rs_nxt;
    logic          start_nxt;
    logic [7:0]    e_byte;
    logic          e_rs;

    always_comb begin
        e_rs   = 1'b0;
        e_byte = 8'h00;
        if (idx == IW'(0))
            e_byte = 8'h38;
        else if (idx == IW'(1))
            e_byte = 8'h0C;
        else if (idx == IW'(2))
            e_byte = 8'h01;
        else if (idx == IW'(3))
            e_byte = 8'h06;
        else if (idx == IW'(FRAME_IDX))
            e_byte = 8'h80;
        else begin
            e_rs   = 1'b1;
            e_byte = 8'h20;
        end
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IW'(LAST_IDX - k) && !blank[k])
                e_byte = {4'h3, snap[4*k +: 4]};
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        scnt_nxt  = scnt;
        data_nxt  = lcd_data;
        rs_nxt    = lcd_rs;
        start_nxt = lcd_start;
        snap_take = 1'b0;
        case (state)
            S_IDLE: begin
                if (dirty) begin
                    idx_nxt   = IW'(FRAME_IDX);
                    state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                data_nxt  = e_byte;
                rs_nxt    = e_rs;
                start_nxt = 1'b1;
                snap_take = (idx == IW'(FRAME_IDX));
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (lcd_done) begin
                    start_nxt = 1'b0;
                    scnt_nxt  = '0;
                    state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (scnt == SET_LAST)
                    state_nxt = S_NEXT;
                else
                    scnt_nxt = scnt + SW'(1);
            end
            S_NEXT: begin
                if (idx == IW'(LAST_IDX)) begin
                    state_nxt = S_IDLE;
                end else begin
                    idx_nxt   = idx + IW'(1);
                    state_nxt = S_SEND;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // reset lands on the first init write; init runs straight into the first frame
    always_ff @(posedge CLOCK_50 or negedge RST) begin
        if (!RST) begin
            state     <= S_SEND;
            idx       <= '0;
            scnt      <= '0;
            lcd_data  <= 8'h00;
            lcd_rs    <= 1'b0;
            lcd_start <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            scnt      <= scnt_nxt;
            lcd_data  <= data_nxt;
            lcd_rs    <= rs_nxt;
            lcd_start <= start_nxt;
        end
    end

endmodule

// File: tb/tb_lcd_bcd_timer.sv
// Bench for lcd_bcd_timer: vector table, LCD byte-stream sequences and a
// randomized run against an integer-valued reference model.
module tb_lcd_bcd_timer;
    localparam int D    = 4;
    localparam int TD   = 4;
    localparam int ST   = 3;
    localparam int LB   = 2;
    localparam int MAXV = 9999;

    logic        CLOCK_50 = 1'b0;
    logic        RST = 1'b1;
    logic        run_toggle = 1'b0;
    logic        dir = 1'b0;
    logic        clear = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_value = '0;
    logic [15:0] count0, count1;
    logic        running0, running1, wrap0, wrap1;
    logic [7:0]  data0, data1;
    logic        rs0, rs1, start0, start1;
    logic        done0 = 1'b0;
    logic        done1 = 1'b0;

    always #5 CLOCK_50 = ~CLOCK_50;

    lcd_bcd_timer #(.DIGITS(D), .TICK_DIV(TD), .SETTLE(ST), .LEAD_BLANKS(LB), .ZERO_BLANK(0)) u0 (
        .CLOCK_50(CLOCK_50), .RST(RST), .run_toggle(run_toggle), .dir(dir),
        .clear(clear), .load(load), .load_value(load_value), .count(count0),
        .running(running0), .wrap(wrap0), .lcd_data(data0), .lcd_rs(rs0),
        .lcd_start(start0), .lcd_done(done0)
    );

    lcd_bcd_timer #(.DIGITS(D), .TICK_DIV(TD), .SETTLE(ST), .LEAD_BLANKS(LB), .ZERO_BLANK(1)) u1 (
        .CLOCK_50(CLOCK_50), .RST(RST), .run_toggle(run_toggle), .dir(dir),
        .clear(clear), .load(load), .load_value(load_value), .count(count1),
        .running(running1), .wrap(wrap1), .lcd_data(data1), .lcd_rs(rs1),
        .lcd_start(start1), .lcd_done(done1)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- controller model and byte logger ----------------
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [8:0] exp_q[$];
    logic [8:0] cap [2];
    logic       prev [2];
    int         dcnt [2];
    int         unstable = 0;
    logic [8:0] lg_cur;
    logic       lg_st;
    logic       lg_dn;

    always @(negedge CLOCK_50) begin
        for (int i = 0; i < 2; i++) begin
            lg_cur = (i == 0) ? {rs0, data0} : {rs1, data1};
            lg_st  = (i == 0) ? start0 : start1;
            lg_dn  = 1'b0;
            if (!RST) begin
                prev[i] = 1'b0;
                dcnt[i] = 0;
            end else begin
                if (lg_st && !prev[i]) begin
                    cap[i]  = lg_cur;
                    dcnt[i] = 5;
                    if (i == 0) q0.push_back(lg_cur);
                    else        q1.push_back(lg_cur);
                end else begin
                    if ((lg_st || prev[i]) && lg_cur !== cap[i])
                        unstable++;
                    if (dcnt[i] > 0) begin
                        dcnt[i]--;
                        if (dcnt[i] == 0) lg_dn = 1'b1;
                    end
                end
                prev[i] = lg_st;
            end
            if (i == 0) done0 = lg_dn;
            else        done1 = lg_dn;
        end
    end

    // ---------------- reference model (integer value) ----------------
    int m_val;
    int m_acc;
    bit m_run;
    bit m_wrap;

    function automatic int bcd2int_sat(input logic [15:0] v);
        int r;
        int d;
        r = 0;
        for (int k = D - 1; k >= 0; k--) begin
            d = int'(v[4*k +: 4]);
            if (d > 9) d = 9;
            r = r * 10 + d;
        end
        return r;
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r;
        int          t;
        t = v;
        r = '0;
        for (int k = 0; k < D; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_val  = 0;
        m_acc  = 0;
        m_run  = 1'b0;
        m_wrap = 1'b0;
    endtask

    task automatic cycle();
        bit tk;
        tk = m_run && (m_acc == TD - 1);
        m_wrap = 1'b0;
        if (clear) begin
            m_val = 0;
            m_acc = 0;
        end else if (load) begin
            m_val = bcd2int_sat(load_value);
            m_acc = 0;
        end else if (tk) begin
            m_acc = 0;
            if (dir) begin
                m_wrap = (m_val == MAXV);
                m_val  = (m_val + 1) % (MAXV + 1);
            end else begin
                m_wrap = (m_val == 0);
                m_val  = (m_val + MAXV) % (MAXV + 1);
            end
        end else if (m_run) begin
            m_acc++;
        end
        if (run_toggle) m_run = !m_run;
        @(posedge CLOCK_50);
        #1;
        checks++;
        if (count0 !== int2bcd(m_val) || count1 !== int2bcd(m_val) ||
            running0 !== m_run || wrap0 !== m_wrap) begin
            failures++;
            $display("FAIL model: count=%h/%h run=%b wrap=%b expected count=%h run=%b wrap=%b",
                     count0, count1, running0, wrap0, int2bcd(m_val), m_run, m_wrap);
        end
    endtask

    task automatic do_reset();
        RST = 1'b0;
        #1;
        check("rst_start", {start0, start1}, 2'b00);
        repeat (2) @(negedge CLOCK_50);
        q0.delete();
        q1.delete();
        model_reset();
        RST = 1'b1;
    endtask

    task automatic check_q(input string name, input int which);
        logic [8:0] a[$];
        if (which == 0) a = q0;
        else            a = q1;
        check({name, "_len"}, a.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < a.size(); k++)
            check(name, a[k], exp_q[k]);
    endtask

    task automatic wait_first_byte();
        int n;
        n = 0;
        while (q0.size() == 0 && n < 200) begin
            cycle();
            n++;
        end
        check("frame_start", q0.size() != 0, 1);
    endtask

    task automatic load_val(input logic [15:0] v);
        load = 1'b1;
        load_value = v;
        cycle();
        load = 1'b0;
    endtask

    // ---------------- counter vector table ----------------
    typedef struct {
        logic        tog;
        logic        clr;
        logic        ld;
        logic        dr;
        logic [15:0] ldv;
        int          idle;
        logic [15:0] ec;
        logic        ew;
        logic        er;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic tog, input logic clr, input logic ld, input logic dr,
                                input logic [15:0] ldv, input int idle,
                                input logic [15:0] ec, input logic ew, input logic er);
        vec_t v;
        v.tog = tog; v.clr = clr; v.ld = ld; v.dr = dr; v.ldv = ldv;
        v.idle = idle; v.ec = ec; v.ew = ew; v.er = er;
        return v;
    endfunction

    initial begin
        model_reset();
        #2;
        RST = 1'b0;
        #1;
        check("rst_count", count0, 16'h0000);
        check("rst_running", running0, 1'b0);
        check("rst_wrap", wrap0, 1'b0);
        check("rst_lcd", {start0, rs0, data0}, 10'h000);
        check("rst_lcd_zb", {start1, rs1, data1}, 10'h000);
        repeat (2) @(negedge CLOCK_50);
        RST = 1'b1;

        // init sequence followed by one frame showing zero
        repeat (300) cycle();
        exp_q = {9'h038, 9'h00C, 9'h001, 9'h006, 9'h080, 9'h120, 9'h120,
                 9'h130, 9'h130, 9'h130, 9'h130};
        check_q("init_seq", 0);
        exp_q = {9'h038, 9'h00C, 9'h001, 9'h006, 9'h080, 9'h120, 9'h120,
                 9'h120, 9'h120, 9'h120, 9'h130};
        check_q("init_seq_zb", 1);

        // a change produces one frame
        q0.delete();
        q1.delete();
        load_val(16'h0042);
        repeat (200) cycle();
        exp_q = {9'h080, 9'h120, 9'h120, 9'h130, 9'h130, 9'h134, 9'h132};
        check_q("frame_42", 0);
        exp_q = {9'h080, 9'h120, 9'h120, 9'h120, 9'h120, 9'h134, 9'h132};
        check_q("frame_42_zb", 1);

        // three changes inside one frame: snapshot frame, then one final frame
        q0.delete();
        q1.delete();
        load_val(16'h1111);
        wait_first_byte();
        repeat (3) cycle();
        load_val(16'h2222);
        repeat (10) cycle();
        load_val(16'h3333);
        repeat (10) cycle();
        load_val(16'h4444);
        repeat (400) cycle();
        exp_q = {9'h080, 9'h120, 9'h120, 9'h131, 9'h131, 9'h131, 9'h131,
                 9'h080, 9'h120, 9'h120, 9'h134, 9'h134, 9'h134, 9'h134};
        check_q("coherent", 0);

        // reset in the middle of a frame restarts from the init sequence
        q0.delete();
        q1.delete();
        load_val(16'h0007);
        wait_first_byte();
        repeat (20) cycle();
        do_reset();
        repeat (300) cycle();
        exp_q = {9'h038, 9'h00C, 9'h001, 9'h006, 9'h080, 9'h120, 9'h120,
                 9'h120, 9'h120, 9'h120, 9'h130};
        check_q("rst_restart_zb", 1);

        // vector table from a fresh reset: count 0, stopped, divider 0
        vt.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0));
        vt.push_back(mk(0, 0, 1, 0, 16'h1234, 0, 16'h1234, 0, 0));
        vt.push_back(mk(0, 0, 1, 0, 16'h12F4, 0, 16'h1294, 0, 0));
        vt.push_back(mk(0, 1, 1, 0, 16'h1234, 0, 16'h0000, 0, 0));
        vt.push_back(mk(0, 0, 1, 0, 16'h0100, 0, 16'h0100, 0, 0));
        vt.push_back(mk(1, 0, 0, 0, 16'h0000, 3, 16'h0100, 0, 1));
        vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 16'h0099, 0, 1));
        vt.push_back(mk(0, 0, 1, 0, 16'h0000, 3, 16'h0000, 0, 1));
        vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 16'h9999, 1, 1));
        vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 16'h9999, 0, 1));
        vt.push_back(mk(0, 0, 1, 1, 16'h9998, 3, 16'h9998, 0, 1));
        vt.push_back(mk(0, 0, 0, 1, 16'h0000, 0, 16'h9999, 0, 1));
        vt.push_back(mk(0, 0, 0, 1, 16'h0000, 3, 16'h0000, 1, 1));
        vt.push_back(mk(0, 0, 0, 1, 16'h0000, 1, 16'h0000, 0, 1));
        vt.push_back(mk(0, 0, 0, 1, 16'h0000, 0, 16'h0000, 0, 1));
        vt.push_back(mk(1, 0, 0, 1, 16'h0000, 0, 16'h0001, 0, 0));
        vt.push_back(mk(0, 0, 0, 1, 16'h0000, 5, 16'h0001, 0, 0));
        vt.push_back(mk(1, 0, 0, 1, 16'h0000, 3, 16'h0001, 0, 1));
        vt.push_back(mk(0, 1, 1, 1, 16'h1234, 0, 16'h0000, 0, 1));
        vt.push_back(mk(0, 0, 1, 1, 16'h1234, 0, 16'h1234, 0, 1));
        vt.push_back(mk(1, 0, 0, 1, 16'h0000, 0, 16'h1234, 0, 0));
        vt.push_back(mk(0, 0, 1, 1, 16'h12F4, 0, 16'h1294, 0, 0));
        for (int i = 0; i < vt.size(); i++) begin
            run_toggle = vt[i].tog;
            clear      = vt[i].clr;
            load       = vt[i].ld;
            dir        = vt[i].dr;
            load_value = vt[i].ldv;
            cycle();
            run_toggle = 1'b0;
            clear      = 1'b0;
            load       = 1'b0;
            repeat (vt[i].idle) cycle();
            check($sformatf("vec%0d", i), {count0, wrap0, running0}, {vt[i].ec, vt[i].ew, vt[i].er});
        end

        // full up-count from zero to 9999 and the wrap back to 0000
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        dir = 1'b1;
        run_toggle = 1'b1;
        cycle();
        run_toggle = 1'b0;
        repeat (4 * 9999) cycle();
        check("full_9999", {count0, wrap0}, {16'h9999, 1'b0});
        repeat (4) cycle();
        check("full_wrap", {count0, wrap0}, {16'h0000, 1'b1});
        cycle();
        check("wrap_pulse", wrap0, 1'b0);
        run_toggle = 1'b1;
        cycle();
        run_toggle = 1'b0;

        // randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            run_toggle = ($urandom_range(0, 39) == 0);
            clear      = ($urandom_range(0, 199) == 0);
            load       = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 29) == 0) dir = ~dir;
            case ($urandom_range(0, 3))
                0:       load_value = 16'h9999;
                1:       load_value = 16'h0000;
                2:       load_value = 16'h9998;
                default: load_value = 16'($urandom);
            endcase
            cycle();
        end
        run_toggle = 1'b0;
        clear      = 1'b0;
        load       = 1'b0;
        repeat (400) cycle();

        check("lcd_stable", unstable, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
